// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions: controller state encoding and RV32M funct3 codes.
// Used by m_ext_ctrl and its optional result cache (M_EXT_RESULT_CACHE_EN).
package m_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_RUN = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_RESP    = 3'd3,
    ST_DRAIN   = 3'd4
  } ctrl_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // The top funct3 bit separates the divide/remainder family from the multiplies.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/m_ext_res_cache.sv
// Single-entry result cache for the M-extension controller.
// Only instantiated when M_EXT_RESULT_CACHE_EN is defined.
module m_ext_res_cache
  import m_ext_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter logic [2:0] F3_MASK = 3'b111
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_lkp_f3,
  input  logic [XLEN-1:0] i_lkp_a,
  input  logic [XLEN-1:0] i_lkp_b,
  output logic            o_hit,
  output logic [XLEN-1:0] o_res,
  input  logic            i_upd,
  input  logic [2:0]      i_upd_f3,
  input  logic [XLEN-1:0] i_upd_a,
  input  logic [XLEN-1:0] i_upd_b,
  input  logic [XLEN-1:0] i_upd_res,
  input  logic            i_inv
);

  logic            entry_valid;
  logic [2:0]      entry_f3;
  logic [XLEN-1:0] entry_a;
  logic [XLEN-1:0] entry_b;
  logic [XLEN-1:0] entry_res;

  // Invalidation wins over a same-cycle update so a flushed op can never be cached.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      entry_valid <= 1'b0;
      entry_f3    <= '0;
      entry_a     <= '0;
      entry_b     <= '0;
      entry_res   <= '0;
    end else if (i_inv) begin
      entry_valid <= 1'b0;
    end else if (i_upd) begin
      entry_valid <= 1'b1;
      entry_f3    <= i_upd_f3;
      entry_a     <= i_upd_a;
      entry_b     <= i_upd_b;
      entry_res   <= i_upd_res;
    end
  end

  assign o_hit = entry_valid
              && ((i_lkp_f3 & F3_MASK) == (entry_f3 & F3_MASK))
              && (i_lkp_a == entry_a)
              && (i_lkp_b == entry_b);
  assign o_res = entry_res;

endmodule

// File: rtl/m_ext_ctrl.sv
// Sequencer between the core and the multiply/divide units for the M extension.
// Define M_EXT_RESULT_CACHE_EN to add a single-entry result cache.
module m_ext_ctrl
  import m_ext_pkg::*;
#(
  parameter int         XLEN          = 32,
  parameter logic [2:0] CACHE_F3_MASK = 3'b111
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_res,
  output logic            o_mul_start,
  output logic [2:0]      o_mul_f3,
  output logic [XLEN-1:0] o_mul_a,
  output logic [XLEN-1:0] o_mul_b,
  input  logic            i_mul_done,
  input  logic [XLEN-1:0] i_mul_res,
  output logic            o_div_start,
  output logic [2:0]      o_div_f3,
  output logic [XLEN-1:0] o_div_a,
  output logic [XLEN-1:0] o_div_b,
  input  logic            i_div_done,
  input  logic [XLEN-1:0] i_div_res
);

  ctrl_state_t     state;
  logic [2:0]      op_f3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            accept;
  logic            inflight_done;

  assign accept        = i_valid && (state == ST_IDLE) && !i_flush;
  assign inflight_done = is_div_op(op_f3) ? i_div_done : i_mul_done;

`ifdef M_EXT_RESULT_CACHE_EN
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;
  logic            cache_upd;
  logic            cache_inv;

  assign cache_upd = (state == ST_RESP) && !i_flush;
  assign cache_inv = i_flush && ((state == ST_MUL_RUN) || (state == ST_DIV_RUN)
                              || (state == ST_RESP));

  m_ext_res_cache #(
    .XLEN    (XLEN),
    .F3_MASK (CACHE_F3_MASK)
  ) u_res_cache (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_lkp_f3  (i_f3),
    .i_lkp_a   (i_rs1),
    .i_lkp_b   (i_rs2),
    .o_hit     (cache_hit),
    .o_res     (cache_res),
    .i_upd     (cache_upd),
    .i_upd_f3  (op_f3),
    .i_upd_a   (op_a),
    .i_upd_b   (op_b),
    .i_upd_res (o_res),
    .i_inv     (cache_inv)
  );
`endif

  // Start strobes default low so each one lasts exactly the first run cycle.
  // A flush landing on the done cycle skips DRAIN, since that done is already gone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      op_f3       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      o_res       <= '0;
      o_mul_start <= 1'b0;
      o_div_start <= 1'b0;
    end else begin
      o_mul_start <= 1'b0;
      o_div_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_f3 <= i_f3;
            op_a  <= i_rs1;
            op_b  <= i_rs2;
`ifdef M_EXT_RESULT_CACHE_EN
            if (cache_hit) begin
              o_res <= cache_res;
              state <= ST_RESP;
            end else
`endif
            if (is_div_op(i_f3)) begin
              o_div_start <= 1'b1;
              state       <= ST_DIV_RUN;
            end else begin
              o_mul_start <= 1'b1;
              state       <= ST_MUL_RUN;
            end
          end
        end
        ST_MUL_RUN: begin
          if (i_flush) begin
            state <= i_mul_done ? ST_IDLE : ST_DRAIN;
          end else if (i_mul_done) begin
            o_res <= i_mul_res;
            state <= ST_RESP;
          end
        end
        ST_DIV_RUN: begin
          if (i_flush) begin
            state <= i_div_done ? ST_IDLE : ST_DRAIN;
          end else if (i_div_done) begin
            o_res <= i_div_res;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (inflight_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A flush during the response cycle withdraws the result before the core sees it.
  assign o_ready  = (state == ST_IDLE);
  assign o_valid  = (state == ST_RESP) && !i_flush;

  assign o_mul_f3 = op_f3;
  assign o_mul_a  = op_a;
  assign o_mul_b  = op_b;
  assign o_div_f3 = op_f3;
  assign o_div_a  = op_a;
  assign o_div_b  = op_b;

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Directed self-checking bench for m_ext_ctrl; the unit handshakes are driven by hand.
// The cache scenario adapts to whether M_EXT_RESULT_CACHE_EN is defined.
module tb_m_ext_ctrl;
  import m_ext_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            ready;
  logic            res_valid;
  logic [XLEN-1:0] res;
  logic            mul_start;
  logic [2:0]      mul_f3;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic            mul_done;
  logic [XLEN-1:0] mul_res;
  logic            div_start;
  logic [2:0]      div_f3;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  int checks = 0;
  int errors = 0;
  int mul_starts = 0;
  int div_starts = 0;
  int valid_cnt = 0;
  int both_cnt = 0;
  int ms0, ds0, vc0;
  logic [63:0]     prod;
  logic [XLEN-1:0] mulhu_exp;

  m_ext_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_f3        (f3),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_flush     (flush),
    .o_ready     (ready),
    .o_valid     (res_valid),
    .o_res       (res),
    .o_mul_start (mul_start),
    .o_mul_f3    (mul_f3),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_done  (mul_done),
    .i_mul_res   (mul_res),
    .o_div_start (div_start),
    .o_div_f3    (div_f3),
    .o_div_a     (div_a),
    .o_div_b     (div_b),
    .i_div_done  (div_done),
    .i_div_res   (div_res)
  );

  always #5 clk = ~clk;

  // Running tallies of strobes seen at each active edge.
  always @(posedge clk) begin
    if (mul_start) mul_starts <= mul_starts + 1;
    if (div_start) div_starts <= div_starts + 1;
    if (res_valid) valid_cnt <= valid_cnt + 1;
    if (mul_start && div_start) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] op,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    valid = v;
    f3    = op;
    rs1   = a;
    rs2   = b;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic snapshot();
    ms0 = mul_starts;
    ds0 = div_starts;
    vc0 = valid_cnt;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    mul_done = 1'b0; mul_res = '0; div_done = 1'b0; div_res = '0;
    apply_stimulus(1'b0, 3'b000, '0, '0);
    repeat (2) tick();

    // Reset state
    check_output("rst_ready", ready, 1);
    check_output("rst_valid", res_valid, 0);
    check_output("rst_mul_start", mul_start, 0);
    check_output("rst_div_start", div_start, 0);
    check_output("rst_res", res, 0);
    check_output("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    tick();

    // MUL 7*6, unit busy for 4 run cycles; o_valid in cycle 6 counting accept as cycle 1
    snapshot();
    apply_stimulus(1'b1, F3_MUL, 32'd7, 32'd6);
    check_output("mul_ready_idle", ready, 1);
    tick();
    apply_stimulus(1'b0, 3'b111, 32'd0, 32'd0);
    check_output("mul_start_c2", mul_start, 1);
    check_output("mul_no_div_start", div_start, 0);
    check_output("mul_a_latched", mul_a, 7);
    check_output("mul_b_latched", mul_b, 6);
    check_output("mul_f3_latched", mul_f3, F3_MUL);
    check_output("mul_busy", ready, 0);
    tick();
    check_output("mul_start_c3", mul_start, 0);
    check_output("mul_a_held", mul_a, 7);
    tick();
    tick();
    mul_done = 1'b1; mul_res = 32'd7 * 32'd6;
    check_output("mul_valid_early", res_valid, 0);
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("mul_valid_c6", res_valid, 1);
    check_output("mul_res", res, 42);
    tick();
    check_output("mul_valid_one_cycle", res_valid, 0);
    check_output("mul_ready_back", ready, 1);
    check_output("mul_res_hold", res, 42);
    check_output("mul_start_count", mul_starts - ms0, 1);
    check_output("mul_div_start_count", div_starts - ds0, 0);

    // DIV 100/7, with a stray multiplier done during the divide
    snapshot();
    apply_stimulus(1'b1, F3_DIV, 32'd100, 32'd7);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    check_output("div_start_c2", div_start, 1);
    check_output("div_no_mul_start", mul_start, 0);
    check_output("div_a", div_a, 100);
    check_output("div_b", div_b, 7);
    check_output("div_f3", div_f3, F3_DIV);
    mul_done = 1'b1; mul_res = 32'd999;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("div_ignore_mul_done", res_valid, 0);
    check_output("div_still_busy", ready, 0);
    div_done = 1'b1; div_res = 32'd100 / 32'd7;
    tick();
    div_done = 1'b0; div_res = '0;
    check_output("div_valid", res_valid, 1);
    check_output("div_res", res, 14);
    tick();
    check_output("div_valid_one_cycle", res_valid, 0);
    check_output("div_mul_start_count", mul_starts - ms0, 0);
    check_output("div_start_count", div_starts - ds0, 1);

    // Stray dones while idle
    snapshot();
    mul_done = 1'b1; mul_res = 32'd55; div_done = 1'b1; div_res = 32'd66;
    tick();
    mul_done = 1'b0; div_done = 1'b0;
    tick();
    check_output("stray_valid_count", valid_cnt - vc0, 0);
    check_output("stray_ready", ready, 1);
    check_output("stray_res", res, 14);
    check_output("stray_starts", (mul_starts - ms0) + (div_starts - ds0), 0);

    // Flush while idle blocks acceptance
    snapshot();
    apply_stimulus(1'b1, F3_MUL, 32'd3, 32'd3);
    flush = 1'b1;
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    flush = 1'b0;
    check_output("idle_flush_ready", ready, 1);
    check_output("idle_flush_no_start", mul_start, 0);

    // Flush two cycles into MUL_RUN, unit finishes later in DRAIN
    snapshot();
    apply_stimulus(1'b1, F3_MUL, 32'd5, 32'd9);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("drain_ready", ready, 0);
    check_output("drain_valid", res_valid, 0);
    tick();
    check_output("drain_wait", ready, 0);
    mul_done = 1'b1; mul_res = 32'd45;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("drain_ready_after_done", ready, 1);
    check_output("drain_valid_count", valid_cnt - vc0, 0);
    check_output("drain_res_discarded", res, 14);

    // Flush during RESP withdraws o_valid
    snapshot();
    apply_stimulus(1'b1, F3_MUL, 32'd3, 32'd4);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    mul_done = 1'b1; mul_res = 32'd12;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("resp_valid_before_flush", res_valid, 1);
    flush = 1'b1;
    #1;
    check_output("resp_flush_suppress", res_valid, 0);
    tick();
    flush = 1'b0;
    check_output("resp_flush_ready", ready, 1);
    check_output("resp_flush_valid_count", valid_cnt - vc0, 0);

    // Same request again must start the unit: a flushed result is never reused
    snapshot();
    apply_stimulus(1'b1, F3_MUL, 32'd3, 32'd4);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    check_output("reissue_start", mul_start, 1);
    mul_done = 1'b1; mul_res = 32'd12;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("reissue_valid", res_valid, 1);
    check_output("reissue_res", res, 12);
    tick();

    // Reset mid DIV_RUN, then a late divider done
    snapshot();
    apply_stimulus(1'b1, F3_DIVU, 32'd50, 32'd5);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check_output("midrst_ready", ready, 1);
    check_output("midrst_valid", res_valid, 0);
    check_output("midrst_div_start", div_start, 0);
    check_output("midrst_mul_start", mul_start, 0);
    check_output("midrst_res", res, 0);
    check_output("midrst_div_a", div_a, 0);
    check_output("midrst_div_b", div_b, 0);
    check_output("midrst_div_f3", div_f3, 0);
    tick();
    rst = 1'b0;
    div_done = 1'b1; div_res = 32'd10;
    tick();
    div_done = 1'b0; div_res = '0;
    tick();
    check_output("late_done_ready", ready, 1);
    check_output("late_done_res", res, 0);
    check_output("late_done_valid_count", valid_cnt - vc0, 0);

    // MULHU 0xFFFFFFFF x 0xFFFFFFFF twice
    prod      = 64'hFFFF_FFFF * 64'hFFFF_FFFF;
    mulhu_exp = prod[63:32];
    snapshot();
    apply_stimulus(1'b1, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
    check_output("mulhu1_start", mul_start, 1);
    mul_done = 1'b1; mul_res = mulhu_exp;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("mulhu1_valid", res_valid, 1);
    check_output("mulhu1_res", res, 64'h0000_0000_FFFF_FFFE);
    tick();
    snapshot();
    apply_stimulus(1'b1, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'd0, 32'd0);
`ifdef M_EXT_RESULT_CACHE_EN
    check_output("cache_hit_valid", res_valid, 1);
    check_output("cache_hit_res", res, 64'h0000_0000_FFFF_FFFE);
    check_output("cache_hit_no_mul_start", mul_start, 0);
    check_output("cache_hit_no_div_start", div_start, 0);
    tick();
    check_output("cache_hit_ready", ready, 1);
    check_output("cache_hit_start_count", (mul_starts - ms0) + (div_starts - ds0), 0);
`else
    check_output("nocache_start", mul_start, 1);
    check_output("nocache_valid_early", res_valid, 0);
    mul_done = 1'b1; mul_res = mulhu_exp;
    tick();
    mul_done = 1'b0; mul_res = '0;
    check_output("nocache_valid", res_valid, 1);
    check_output("nocache_res", res, 64'h0000_0000_FFFF_FFFE);
    tick();
    check_output("nocache_start_count", mul_starts - ms0, 1);
`endif

    check_output("never_both_starts", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_ext_ctrl.md
M_EXT_CTRL -- requirements
Module: m_ext_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have parameter CACHE_F3_MASK, default 3'b111, meaning f3 bits compared on a cache lookup.
REQ-003 SHALL have ports: i_clk input 1 clock; i_rst input 1 asynchronous active-high reset.
REQ-004 SHALL have core-side ports: i_valid in 1 request; i_f3 in 3 M-op funct3; i_rs1, i_rs2 in XLEN operands; i_flush in 1 abort; o_ready out 1 accept; o_valid out 1 result strobe; o_res out XLEN result.
REQ-005 SHALL have multiplier-side ports: o_mul_start out 1; o_mul_f3 out 3; o_mul_a, o_mul_b out XLEN; i_mul_done in 1; i_mul_res in XLEN.
REQ-006 SHALL have divider-side ports: o_div_start out 1; o_div_f3 out 3; o_div_a, o_div_b out XLEN; i_div_done in 1; i_div_res in XLEN.

Function
REQ-007 SHALL implement states IDLE, MUL_RUN, DIV_RUN, RESP, DRAIN.
REQ-008 SHALL assert o_ready only in IDLE; a request is accepted when i_valid && o_ready && !i_flush.
REQ-009 SHALL on accept latch i_f3/i_rs1/i_rs2, then go to MUL_RUN if i_f3[2]==0, else DIV_RUN.
REQ-010 SHALL pulse o_mul_start (or o_div_start) for exactly the first cycle of MUL_RUN (DIV_RUN); o_*_a/b/f3 drive latched values throughout the run.
REQ-011 SHALL, on i_mul_done in MUL_RUN (i_div_done in DIV_RUN), register the unit result into o_res and go to RESP.
REQ-012 SHALL assert o_valid for exactly one cycle in RESP, then return to IDLE; o_res holds its value until the next capture.
REQ-013 SHALL give minimum accept-to-o_valid latency = unit latency + 2 cycles.
REQ-014 SHALL ignore i_mul_done/i_div_done in IDLE, RESP and in the non-matching run state.
REQ-015 SHALL, on i_flush in MUL_RUN/DIV_RUN, go to DRAIN, wait for the in-flight unit's done, discard its result, then return to IDLE without o_valid.
REQ-016 SHALL, on i_flush in RESP, suppress o_valid and return to IDLE; i_flush in IDLE blocks acceptance that cycle.
REQ-017 SHALL pass division by zero and signed overflow to the divider unmodified; no special-casing.
REQ-018 SHALL never assert o_mul_start and o_div_start in the same cycle.

Reset
REQ-019 SHALL on i_rst go to IDLE at once, regardless of current state.
REQ-020 SHALL reset o_valid, o_mul_start, o_div_start, o_res, the operand latches and the cache-valid bit to 0.
REQ-021 SHALL, after reset mid-operation, ignore any late done from the interrupted unit; the unit is reset by the same i_rst.

Configuration
REQ-022 SHALL gate a result cache behind macro M_EXT_RESULT_CACHE_EN.
REQ-023 SHALL, with M_EXT_RESULT_CACHE_EN defined, keep the last completed f3/rs1/rs2/result plus a valid bit.
REQ-024 SHALL, on accept of a request matching the cache (f3 masked by CACHE_F3_MASK), go directly to RESP with the cached result and start no unit.
REQ-025 SHALL clear the cache-valid bit on reset and on any flushed operation; update the cache only on a completed, unflushed RESP.
REQ-026 SHALL, without M_EXT_RESULT_CACHE_EN, contain no cache storage; every request starts a unit.

Structure
REQ-027 SHALL place the state encoding and the MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU f3 constants in the shared M-extension package.
REQ-028 SHALL keep the cache in one sub-module, m_ext_res_cache (lookup/update/invalidate ports); no other sub-modules.

Verification
REQ-029 SHALL test MUL: rs1=7, rs2=6, f3=000; unit done after 4 cycles -> one o_mul_start, o_valid 6 cycles after accept, o_res=42.
REQ-030 SHALL test DIV: rs1=100, rs2=7, f3=100 -> only o_div_start pulses, o_res=14, o_mul_start never high.
REQ-031 SHALL test flush: i_flush 2 cycles into MUL_RUN -> DRAIN until done, no o_valid, o_ready returns 1 cycle after done.
REQ-032 SHALL test reset: i_rst mid DIV_RUN, then a late i_div_done -> IDLE, all outputs 0, no o_valid.
REQ-033 SHALL test cache (macro on): MULHU 0xFFFFFFFF x 0xFFFFFFFF twice -> second o_res=0xFFFFFFFE, o_valid 2 cycles after accept, no start pulse.
REQ-034 SHALL test a stray done: i_mul_done pulsed in IDLE -> no state change, no o_valid.
